// File: rtl/mini_src_control_unit_if.sv
// Control bundle between the Mini SRC control sequencer and its datapath.
//   master : the control unit (consumes IR_Data/CON_out, drives all controls)
//   slave  : the datapath side (drives IR_Data/CON_out, consumes controls)
// Signal names match the datapath's existing port names.
interface mini_src_control_unit_if;
  logic [31:0] IR_Data;
  logic        CON_out;
  // register load enables
  logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
  // bus drive enables
  logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
  // memory strobes
  logic Read, Write;
  // select-and-encode controls
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] alu_instruction_bits;
  logic       Run;
  logic [3:0] state_out;

  modport master (
    input  IR_Data, CON_out,
    output PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
    output PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
    output Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
    output alu_instruction_bits, Run, state_out
  );

  modport slave (
    output IR_Data, CON_out,
    input  PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
    input  PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
    input  Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
    input  alu_instruction_bits, Run, state_out
  );
endinterface

// File: rtl/mini_src_control_unit.sv
// Mini SRC hardwired control sequencer.
// Moore FSM stepping RESET -> T0..T7 per instruction (HALTED after halt).
// Outputs are a combinational decode of (state, IR[31:27]).
// Ports:
//   clk : rising-edge clock
//   clr : synchronous active-high reset (wins over every state)
//   bus : control bundle, master side (IR_Data/CON_out in, controls out)
module mini_src_control_unit #(
  parameter int         OPW     = 5,
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] ALU_AND = 5'b00101,
  parameter logic [4:0] ALU_OR  = 5'b00110
) (
  input  logic                     clk,
  input  logic                     clr,
  mini_src_control_unit_if.master  bus
);
  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALTED = 4'd9
  } state_e;

  state_e         state_q, state_d;
  logic           taken_q, taken_d;
  logic [OPW-1:0] op;

  assign op = bus.IR_Data[31 -: OPW];

  // opcode classes
  logic is_ld, is_ldi, is_st, is_mem, is_alu_r, is_imm, is_muldiv, is_negnot;
  logic is_br, is_jr, is_in, is_out, is_mfhi, is_mflo, is_halt, br_go;
  always_comb begin
    is_ld     = (op == 5'd0);
    is_ldi    = (op == 5'd1);
    is_st     = (op == 5'd2);
    is_mem    = is_ld | is_ldi | is_st;
    is_alu_r  = (op >= 5'd3) && (op <= 5'd11);
    is_imm    = (op >= 5'd12) && (op <= 5'd14);
    is_muldiv = (op == 5'd15) || (op == 5'd16);
    is_negnot = (op == 5'd17) || (op == 5'd18);
    is_br     = (op == 5'd19);
    is_jr     = (op == 5'd20);
    is_in     = (op == 5'd22);
    is_out    = (op == 5'd23);
    is_mfhi   = (op == 5'd24);
    is_mflo   = (op == 5'd25);
    is_halt   = (op == 5'd27);
    br_go     = is_br & taken_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_RESET;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    case (state_q)
      S_RESET:  state_d = S_T0;
      S_T0:     state_d = S_T1;
      S_T1:     state_d = S_T2;
      S_T2:     state_d = S_T3;
      S_T3: begin
        // branch decision is captured here; later br steps only run if taken
        taken_d = bus.CON_out;
        if (is_br)                                             state_d = bus.CON_out ? S_T4 : S_T0;
        else if (is_mem | is_alu_r | is_imm | is_muldiv | is_negnot) state_d = S_T4;
        else if (is_halt)                                      state_d = S_HALTED;
        else                                                   state_d = S_T0;
      end
      S_T4:     state_d = (is_mem | is_alu_r | is_imm | is_muldiv | br_go) ? S_T5 : S_T0;
      S_T5:     state_d = (is_ld | is_st | is_muldiv | br_go) ? S_T6 : S_T0;
      S_T6:     state_d = (is_ld | is_st) ? S_T7 : S_T0;
      S_T7:     state_d = S_T0;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RESET;
    endcase
  end

  // control decode
  always_comb begin
    bus.PC_in = 1'b0; bus.IR_in = 1'b0; bus.Y_in = 1'b0; bus.Z_in = 1'b0;
    bus.HI_in = 1'b0; bus.LO_in = 1'b0; bus.MAR_in = 1'b0; bus.MDR_in = 1'b0;
    bus.OutPort_in = 1'b0; bus.IncPC = 1'b0;
    bus.PC_out = 1'b0; bus.Zhigh_out = 1'b0; bus.Zlow_out = 1'b0; bus.HI_out = 1'b0;
    bus.LO_out = 1'b0; bus.MDR_out = 1'b0; bus.InPort_out = 1'b0; bus.C_out = 1'b0;
    bus.Read = 1'b0; bus.Write = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0;
    bus.BAout = 1'b0;
    bus.alu_instruction_bits = 5'b0;
    bus.Run       = (state_q != S_HALTED);
    bus.state_out = state_q;
    case (state_q)
      S_T0: begin bus.PC_out = 1'b1; bus.MAR_in = 1'b1; bus.IncPC = 1'b1; bus.Z_in = 1'b1; end
      S_T1: begin bus.Zlow_out = 1'b1; bus.PC_in = 1'b1; bus.Read = 1'b1; bus.MDR_in = 1'b1; end
      S_T2: begin bus.MDR_out = 1'b1; bus.IR_in = 1'b1; end
      S_T3: begin
        if (is_mem) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Y_in = 1'b1;
        end else if (is_alu_r | is_imm) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Y_in = 1'b1;
        end else if (is_muldiv) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Y_in = 1'b1;
        end else if (is_negnot) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Z_in = 1'b1; bus.alu_instruction_bits = op;
        end else if (is_br) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1;
        end else if (is_jr) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PC_in = 1'b1;
        end else if (is_in) begin
          bus.InPort_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (is_out) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPort_in = 1'b1;
        end else if (is_mfhi) begin
          bus.HI_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (is_mflo) begin
          bus.LO_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      S_T4: begin
        if (is_mem) begin
          bus.C_out = 1'b1; bus.Z_in = 1'b1; bus.alu_instruction_bits = ALU_ADD;
        end else if (is_alu_r | is_muldiv) begin
          // register ops read Rc, mul/div read Rb as the second operand
          bus.Grc = is_alu_r; bus.Grb = is_muldiv;
          bus.Rout = 1'b1; bus.Z_in = 1'b1; bus.alu_instruction_bits = op;
        end else if (is_imm) begin
          bus.C_out = 1'b1; bus.Z_in = 1'b1;
          bus.alu_instruction_bits = (op == 5'd12) ? ALU_ADD : (op == 5'd13) ? ALU_AND : ALU_OR;
        end else if (is_negnot) begin
          bus.Zlow_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (br_go) begin
          bus.PC_out = 1'b1; bus.Y_in = 1'b1;
        end
      end
      S_T5: begin
        if (is_ldi | is_alu_r | is_imm) begin
          bus.Zlow_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (is_ld | is_st) begin
          bus.Zlow_out = 1'b1; bus.MAR_in = 1'b1;
        end else if (is_muldiv) begin
          bus.Zlow_out = 1'b1; bus.LO_in = 1'b1;
        end else if (br_go) begin
          bus.C_out = 1'b1; bus.Z_in = 1'b1; bus.alu_instruction_bits = ALU_ADD;
        end
      end
      S_T6: begin
        if (is_ld) begin
          bus.Read = 1'b1; bus.MDR_in = 1'b1;
        end else if (is_st) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDR_in = 1'b1;
        end else if (is_muldiv) begin
          bus.Zhigh_out = 1'b1; bus.HI_in = 1'b1;
        end else if (br_go) begin
          bus.Zlow_out = 1'b1; bus.PC_in = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          bus.MDR_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (is_st) begin
          bus.Write = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule
